ov7670_stream_gen: RTL and testbench

//  OV7670-style camera emulator: reads RGB444 pixels from a frame buffer and drives the
//  D/href/vsync byte stream expected by the pixel capture block, two bytes per pixel.

---
 rtl/ov7670_stream_gen_if.sv | 22 ++
 rtl/ov7670_stream_gen.sv | 154 +++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_stream_gen_if.sv
// Frame-buffer read port plus OV7670-style D/href/vsync byte stream.
// master = stream generator, slave = frame buffer / capture side.
interface ov7670_stream_gen_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic [7:0]        D;
  logic              href;
  logic              vsync;

  modport master (
    output rd_en, rd_addr, D, href, vsync,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, D, href, vsync,
    output rd_data
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera emulator: frame-buffer RGB444 pixels out as
// a two-bytes-per-pixel D/href/vsync stream for the capture path.
module ov7670_stream_gen #(
  parameter int H_ACTIVE  = 32,
  parameter int V_ACTIVE  = 24,
  parameter int H_BLANK   = 8,
  parameter int VSYNC_LEN = 4,
  parameter int V_FRONT   = 6,
  parameter int V_BACK    = 6,
  parameter int ADDR_W    = 10
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic enable,
  output logic busy,
  output logic frame_done,
  ov7670_stream_gen_if.master bus
);
  localparam int BYTES = 2 * H_ACTIVE;
  localparam int BW = $clog2(BYTES);
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int M1 = (VSYNC_LEN > V_FRONT) ? VSYNC_LEN : V_FRONT;
  localparam int M2 = (H_BLANK > V_BACK) ? H_BLANK : V_BACK;
  localparam int CW = $clog2((M1 > M2) ? M1 : M2);

  localparam logic [CW-1:0] VS_END = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] VF_END = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] VF_RD  = CW'(V_FRONT - 2);
  localparam logic [CW-1:0] HB_END = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] HB_RD  = CW'(H_BLANK - 2);
  localparam logic [CW-1:0] VB_END = CW'(V_BACK - 1);
  localparam logic [BW-1:0] B_END  = BW'(BYTES - 1);
  localparam logic [BW-1:0] B_NORD = BW'(BYTES - 2);
  localparam logic [LW-1:0] L_END  = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VFRONT,
    S_LINE,
    S_HBLANK,
    S_VBACK
  } state_t;

  state_t        state, n_state;
  logic [CW-1:0] cnt, n_cnt;
  logic [BW-1:0] bcnt, n_bcnt;
  logic [LW-1:0] lcnt, n_lcnt;
  logic          n_rd;
  logic          first;
  logic          cap;
  logic [7:0]    pix;

  always_comb begin
    n_state = state;
    n_cnt   = cnt + 1'b1;
    n_bcnt  = bcnt + 1'b1;
    n_lcnt  = lcnt;
    unique case (state)
      S_IDLE: begin
        n_cnt = '0;
        if (enable) n_state = S_VSYNC;
      end
      S_VSYNC: begin
        if (cnt == VS_END) begin
          n_state = S_VFRONT;
          n_cnt   = '0;
        end
      end
      S_VFRONT: begin
        if (cnt == VF_END) begin
          n_state = S_LINE;
          n_bcnt  = '0;
          n_lcnt  = '0;
        end
      end
      S_LINE: begin
        if (bcnt == B_END) begin
          n_bcnt = '0;
          n_cnt  = '0;
          if (lcnt == L_END) begin
            n_state = S_VBACK;
          end else begin
            n_state = S_HBLANK;
            n_lcnt  = lcnt + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt == HB_END) begin
          n_state = S_LINE;
          n_bcnt  = '0;
        end
      end
      S_VBACK: begin
        if (cnt == VB_END) begin
          n_state = enable ? S_VSYNC : S_IDLE;
          n_cnt   = '0;
        end
      end
      default: n_state = S_IDLE;
    endcase
    // reads lead their byte0 by two cycles
    n_rd = (n_state == S_VFRONT && n_cnt == VF_RD)
        || (n_state == S_HBLANK && n_cnt == HB_RD)
        || (n_state == S_LINE && !n_bcnt[0] && n_bcnt != B_NORD);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bcnt        <= '0;
      lcnt        <= '0;
      first       <= 1'b1;
      cap         <= 1'b0;
      pix         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.D       <= '0;
      bus.href    <= 1'b0;
      bus.vsync   <= 1'b0;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      bcnt       <= n_bcnt;
      lcnt       <= n_lcnt;
      busy       <= n_state != S_IDLE;
      frame_done <= n_state == S_VBACK && n_cnt == VB_END;
      bus.vsync  <= n_state == S_VSYNC;
      bus.href   <= n_state == S_LINE;
      bus.rd_en  <= n_rd;
      cap        <= bus.rd_en;
      if (n_state == S_VSYNC) begin
        first <= 1'b1;
      end else if (n_rd) begin
        first <= 1'b0;
      end
      if (n_rd) begin
        bus.rd_addr <= first ? '0 : bus.rd_addr + 1'b1;
      end
      if (cap) begin
        pix   <= bus.rd_data[7:0];
        bus.D <= {4'h0, bus.rd_data[11:8]};
      end else if (n_state == S_LINE && n_bcnt[0]) begin
        bus.D <= pix;
      end else begin
        bus.D <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench: tiny 2x1 frame cycle-by-cycle, default frame
// captured back into pixels and compared with the buffer.
module tb_ov7670_stream_gen;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_n, en_a, en_b;
  logic busy_a, busy_b, fd_a, fd_b;
  logic mon_b;
  int   checks = 0;
  int   errors = 0;

  ov7670_stream_gen_if #(.ADDR_W(10)) bus_a ();
  ov7670_stream_gen_if #(.ADDR_W(10)) bus_b ();

  ov7670_stream_gen #(
    .H_ACTIVE(2),
    .V_ACTIVE(1)
  ) dut_a (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .enable    (en_a),
    .busy      (busy_a),
    .frame_done(fd_a),
    .bus       (bus_a)
  );

  ov7670_stream_gen dut_b (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .enable    (en_b),
    .busy      (busy_b),
    .frame_done(fd_b),
    .bus       (bus_b)
  );

  logic [11:0] mem_a [1024];
  logic [11:0] mem_b [1024];

  // synchronous frame buffers; garbage whenever no read was issued
  initial forever begin
    @(posedge pclk);
    bus_a.rd_data <= bus_a.rd_en ? mem_a[bus_a.rd_addr] : 12'($urandom);
    bus_b.rd_data <= bus_b.rd_en ? mem_b[bus_b.rd_addr] : 12'($urandom);
  end

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic       re;
    logic       fd;
    logic       bz;
    logic [7:0] d;
    logic [9:0] a;
  } cyc_t;

  typedef struct packed {
    logic [11:0] px;
    logic [31:0] idx;
  } pix_t;

  cyc_t exp_a [$];
  pix_t pix_q [$];
  cyc_t ea, e_tmp;
  pix_t ep, p_tmp;

  function automatic logic [11:0] pat(input int i);
    return 12'(i * 151 + 43);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // per-cycle monitor for the 2x1 frame
  initial forever begin
    @(negedge pclk);
    if (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      check("a_ctl",
            32'({bus_a.vsync, bus_a.href, bus_a.rd_en, fd_a, busy_a}),
            32'({ea.vs, ea.hr, ea.re, ea.fd, ea.bz}));
      check("a_D", 32'(bus_a.D), 32'(ea.d));
      if (ea.re) check("a_addr", 32'(bus_a.rd_addr), 32'(ea.a));
    end
  end

  // capture-side monitor for the default-size stream
  int         wr_addr, rd_exp, lowrun, hirun;
  logic       phase, prev_href;
  logic [3:0] r_hold;

  initial forever begin
    @(negedge pclk);
    if (!mon_b || bus_b.vsync) begin
      wr_addr   = 0;
      rd_exp    = 0;
      phase     = 1'b0;
      lowrun    = -1;
      hirun     = 0;
      prev_href = 1'b0;
    end else begin
      if (bus_b.rd_en) begin
        check("b_rd_addr", 32'(bus_b.rd_addr), 32'(rd_exp));
        rd_exp++;
      end
      if (bus_b.href) begin
        if (!prev_href && lowrun >= 0) check("b_hblank", lowrun, 8);
        hirun++;
        if (!phase) begin
          r_hold = bus_b.D[3:0];
          check("b_byte0_hi", 32'(bus_b.D[7:4]), 0);
        end else begin
          if (pix_q.size() == 0) begin
            check("b_pix_unexpected", 1, 0);
          end else begin
            ep = pix_q.pop_front();
            check("b_pix", 32'({r_hold, bus_b.D}), 32'(ep.px));
            check("b_wr_addr", wr_addr, ep.idx);
          end
          wr_addr++;
        end
        phase = ~phase;
      end else begin
        check("b_idle_D", 32'(bus_b.D), 0);
        if (prev_href) begin
          check("b_href_len", hirun, 64);
          hirun  = 0;
          lowrun = 0;
        end
        if (lowrun >= 0) lowrun++;
        if (fd_b) check("b_reads", rd_exp, 768);
      end
      prev_href = bus_b.href;
    end
  end

  int n;

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    mon_b = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 12'h000;
      mem_b[i] = pat(i);
    end
    mem_a[0] = 12'hCDA;
    mem_a[1] = 12'h561;
    #12;
    check("rst_a", 32'({bus_a.D, bus_a.href, bus_a.vsync, bus_a.rd_en,
                        busy_a, fd_a}), 0);
    check("rst_b", 32'({bus_b.D, bus_b.href, bus_b.vsync, bus_b.rd_en,
                        busy_b, fd_b}), 0);
    check("rst_addr", 32'({bus_a.rd_addr, bus_b.rd_addr}), 0);
    @(negedge pclk);
    rst_n = 1'b1;

    // reset asserted mid-line
    @(negedge pclk);
    en_b = 1'b1;
    n = 0;
    while (bus_b.href !== 1'b1 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("t1_href_seen", 32'(bus_b.href), 1);
    repeat (7) @(negedge pclk);
    #1 rst_n = 1'b0;
    en_b = 1'b0;
    #1 check("t1_rst_now", 32'({bus_b.D, bus_b.href, bus_b.vsync,
                               bus_b.rd_en, busy_b}), 0);
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (4) @(negedge pclk);
    check("t1_idle", 32'({busy_b, bus_b.vsync, bus_b.href, bus_b.rd_en}), 0);

    // 2x1 frame, one cycle per entry from the first vsync cycle
    @(negedge pclk);
    #1;
    for (int i = 0; i < 22; i++) begin
      e_tmp.vs = (i < 4);
      e_tmp.hr = (i >= 10 && i < 14);
      e_tmp.re = (i == 8 || i == 10);
      e_tmp.fd = (i == 19);
      e_tmp.bz = (i < 20);
      e_tmp.d  = (i == 10) ? 8'h0C : (i == 11) ? 8'hDA :
                 (i == 12) ? 8'h05 : (i == 13) ? 8'h61 : 8'h00;
      e_tmp.a  = (i == 10) ? 10'd1 : 10'd0;
      exp_a.push_back(e_tmp);
    end
    en_a = 1'b1;
    @(posedge pclk);
    #1 en_a = 1'b0;
    n = 0;
    while (exp_a.size() > 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("a_drained", exp_a.size(), 0);

    // two back-to-back default frames, enable dropped in the second
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 768; i++) begin
        p_tmp.px  = pat(i);
        p_tmp.idx = i;
        pix_q.push_back(p_tmp);
      end
    end
    mon_b = 1'b1;
    @(negedge pclk);
    #1 en_b = 1'b1;
    n = 0;
    while (fd_b !== 1'b1 && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    check("b_frame_len", n, 1736);
    @(negedge pclk);
    check("b_back_to_back", 32'({busy_b, bus_b.vsync}), 32'(2'b11));
    repeat (100) @(negedge pclk);
    #1 en_b = 1'b0;
    n = 0;
    while (fd_b !== 1'b1 && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    check("b_finish_len", n, 1635);
    @(negedge pclk);
    check("b_idle_after", 32'({busy_b, bus_b.vsync, bus_b.href}), 0);
    repeat (5) @(negedge pclk);
    check("b_stays_idle", 32'({busy_b, bus_b.rd_en}), 0);
    check("b_pix_drained", pix_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
